// File: rtl/ir_pkg.sv
// ir_pkg: shared types and helpers for the IR transmit framer.
//   ir_tx_state_t : framer FSM states
//   len_width     : bits needed to hold a count of 0..max_len
//   cnt_width     : bits needed for a duration counter running 0..max_dur-1
//   max2          : larger of two unsigned values
//   even_parity   : XOR reduction of a (zero-extended) payload
package ir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StSpace,
        StMark,
        StTail,
        StGap
    } ir_tx_state_t;

    // Widest payload the parity helper accepts; callers zero-extend into it.
    localparam int unsigned PARITY_MAX_W = 64;

    function automatic int unsigned len_width(input int unsigned max_len);
        return (max_len < 1) ? 1 : int'($clog2(max_len + 1));
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_dur);
        return (max_dur <= 2) ? 1 : int'($clog2(max_dur));
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ir_tx_framer_if.sv
// ir_tx_framer_if: message handshake between the message builder and the framer.
//   data_valid_in : message offered (builder -> framer)
//   ready_out     : framer idle and able to accept (framer -> builder)
//   data_in       : payload, bits [len-1:0] used
//   len_in        : payload length, 0 means MAX_LEN
//   lsb_first_in  : 0 = MSB first, 1 = LSB first
//   repeat_in     : extra repeats (total frames = repeat_in + 1)
// Modports: master (message builder), slave (framer).
interface ir_tx_framer_if #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned REP_W   = 4
);
    import ir_pkg::*;

    localparam int unsigned LEN_W = len_width(MAX_LEN);

    logic               data_valid_in;
    logic               ready_out;
    logic [MAX_LEN-1:0] data_in;
    logic [LEN_W-1:0]   len_in;
    logic               lsb_first_in;
    logic [REP_W-1:0]   repeat_in;

    modport master (
        output data_valid_in,
        output data_in,
        output len_in,
        output lsb_first_in,
        output repeat_in,
        input  ready_out
    );

    modport slave (
        input  data_valid_in,
        input  data_in,
        input  len_in,
        input  lsb_first_in,
        input  repeat_in,
        output ready_out
    );

endinterface

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: free-running carrier counter, high for counts 0..CARRIER_HIGH-1
// of every CARRIER_PERIOD-cycle period.
//   clk_in      : system clock
//   rst_in      : synchronous reset, active-high
//   restart_in  : forces the count to 0 on the next edge (phase alignment)
//   carrier_out : carrier level for the current count
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int unsigned CARRIER_PERIOD = 2_560,
    parameter int unsigned CARRIER_HIGH   = 1_280
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic restart_in,
    output logic carrier_out
);

    localparam int unsigned CW = cnt_width(CARRIER_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(CARRIER_PERIOD - 1);
    localparam logic [CW-1:0] HIGH = CW'(CARRIER_HIGH);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart_in || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carrier_out = (cnt_q < HIGH);

endmodule

// File: rtl/ir_tx_framer.sv
// ir_tx_framer: serialises a variable-length message as pulse-width-coded marks on a
// carrier. Frame = SYNC mark, then per bit a BSD space plus a BBD0/BBD1 mark, then a
// BSD tail space; optional repeats separated by RGD gaps.
//   clk_in       : system clock
//   rst_in       : synchronous reset, active-high (overrides abort)
//   msg          : message handshake (ir_tx_framer_if.slave)
//   abort_in     : cancel transmission, back to idle without done
//   busy_out     : transmission in progress
//   done_out     : one-cycle pulse when the final frame completes
//   envelope_out : registered unmodulated mark envelope
//   signal_out   : registered carrier-modulated LED drive
// Build option: define IR_TX_PARITY_EN to append an even-parity bit to every frame.
// The interface instance must use the same MAX_LEN and REP_W as this module.
module ir_tx_framer
    import ir_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 32,
    parameter int unsigned SBD            = 240_000,
    parameter int unsigned BSD            = 60_000,
    parameter int unsigned BBD0           = 60_000,
    parameter int unsigned BBD1           = 120_000,
    parameter int unsigned RGD            = 1_000_000,
    parameter int unsigned CARRIER_PERIOD = 2_560,
    parameter int unsigned CARRIER_HIGH   = 1_280,
    parameter int unsigned REP_W          = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    ir_tx_framer_if.slave msg,
    input  logic          abort_in,
    output logic          busy_out,
    output logic          done_out,
    output logic          envelope_out,
    output logic          signal_out
);

`ifdef IR_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    localparam int unsigned LEN_W   = len_width(MAX_LEN);
    localparam int unsigned NB_W    = len_width(MAX_LEN + 1);
    localparam int unsigned FW      = MAX_LEN + 1;
    localparam int unsigned MAX_DUR = max2(max2(SBD, BSD), max2(max2(BBD0, BBD1), RGD));
    localparam int unsigned CNT_W   = cnt_width(MAX_DUR);

    localparam logic [CNT_W-1:0] SBD_LAST  = CNT_W'(SBD - 1);
    localparam logic [CNT_W-1:0] BSD_LAST  = CNT_W'(BSD - 1);
    localparam logic [CNT_W-1:0] BBD0_LAST = CNT_W'(BBD0 - 1);
    localparam logic [CNT_W-1:0] BBD1_LAST = CNT_W'(BBD1 - 1);
    localparam logic [CNT_W-1:0] RGD_LAST  = CNT_W'(RGD - 1);

    ir_tx_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [FW-1:0]    sr_q, sr_d;
    logic [NB_W-1:0]  nbits_q, nbits_d;
    logic [NB_W-1:0]  bits_left_q, bits_left_d;
    logic             cur_bit_q, cur_bit_d;
    logic [REP_W-1:0] rep_left_q, rep_left_d;
    logic             env_q, sig_q, done_q, done_d;
    logic             next_bit, mark, carrier, restart;

    // Incoming message rearranged into transmit order: bit 0 goes out first.
    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] mask, payload, rev, msb_word;
    logic [FW-1:0]      word;
    logic [NB_W-1:0]    total_bits;

    always_comb begin
        len_eff  = (msg.len_in == '0) ? LEN_W'(MAX_LEN) : msg.len_in;
        mask     = ~({MAX_LEN{1'b1}} << len_eff);
        payload  = msg.data_in & mask;
        rev      = {<<{msg.data_in}};
        // After reversal data[len-1] sits at MAX_LEN-len; shift it down to bit 0.
        msb_word = (rev >> (LEN_W'(MAX_LEN) - len_eff)) & mask;
        word     = {1'b0, msg.lsb_first_in ? payload : msb_word};
        if (PAR_BITS != 0) begin
            word = word | (FW'(even_parity(PARITY_MAX_W'(payload))) << len_eff);
        end
        total_bits = NB_W'(len_eff) + NB_W'(PAR_BITS);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        frame_d     = frame_q;
        sr_d        = sr_q;
        nbits_d     = nbits_q;
        bits_left_d = bits_left_q;
        cur_bit_d   = cur_bit_q;
        rep_left_d  = rep_left_q;
        done_d      = 1'b0;
        next_bit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (msg.data_valid_in) begin
                    frame_d     = word;
                    sr_d        = word;
                    nbits_d     = total_bits;
                    bits_left_d = total_bits;
                    rep_left_d  = msg.repeat_in;
                    state_d     = StSync;
                end
            end
            StSync: begin
                if (cnt_q == SBD_LAST) begin
                    state_d  = StSpace;
                    next_bit = 1'b1;
                end
            end
            StSpace: begin
                if (cnt_q == BSD_LAST) begin
                    state_d = StMark;
                end
            end
            StMark: begin
                if (cnt_q == (cur_bit_q ? BBD1_LAST : BBD0_LAST)) begin
                    if (bits_left_q == '0) begin
                        state_d = StTail;
                    end else begin
                        state_d  = StSpace;
                        next_bit = 1'b1;
                    end
                end
            end
            StTail: begin
                if (cnt_q == BSD_LAST) begin
                    if (rep_left_q != '0) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StGap: begin
                if (cnt_q == RGD_LAST) begin
                    state_d     = StSync;
                    rep_left_d  = rep_left_q - 1'b1;
                    sr_d        = frame_q;
                    bits_left_d = nbits_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // The bit for the upcoming SPACE+MARK pair is picked on SPACE entry.
        if (next_bit) begin
            cur_bit_d   = sr_q[0];
            sr_d        = sr_q >> 1;
            bits_left_d = bits_left_q - 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (abort_in && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign mark    = (state_q == StSync) || (state_q == StMark);
    assign restart = (state_d == StSync) && (state_q != StSync);

    ir_carrier_gen #(
        .CARRIER_PERIOD (CARRIER_PERIOD),
        .CARRIER_HIGH   (CARRIER_HIGH)
    ) u_carrier (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .restart_in  (restart),
        .carrier_out (carrier)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_q     <= '0;
            sr_q        <= '0;
            nbits_q     <= '0;
            bits_left_q <= '0;
            cur_bit_q   <= 1'b0;
            rep_left_q  <= '0;
            env_q       <= 1'b0;
            sig_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            sr_q        <= sr_d;
            nbits_q     <= nbits_d;
            bits_left_q <= bits_left_d;
            cur_bit_q   <= cur_bit_d;
            rep_left_q  <= rep_left_d;
            // Abort blanks the outputs on the same edge the FSM returns to idle.
            env_q       <= mark && !abort_in;
            sig_q       <= mark && carrier && !abort_in;
            done_q      <= done_d;
        end
    end

    assign msg.ready_out = (state_q == StIdle);
    assign busy_out      = (state_q != StIdle);
    assign done_out      = done_q;
    assign envelope_out  = env_q;
    assign signal_out    = sig_q;

endmodule

// File: tb/tb_ir_tx_framer.sv
// tb_ir_tx_framer: directed and randomised checks of ir_tx_framer against a
// cycle-list reference model built from the frame timing rules.
module tb_ir_tx_framer;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned REP_W   = 4;
    localparam int unsigned SBD     = 8;
    localparam int unsigned BSD     = 2;
    localparam int unsigned BBD0    = 2;
    localparam int unsigned BBD1    = 4;
    localparam int unsigned RGD     = 6;
    localparam int unsigned CP      = 2;
    localparam int unsigned CH      = 1;

    logic clk_in = 1'b0;
    logic rst_in;
    logic abort_in;
    logic busy_out, done_out, envelope_out, signal_out;

    ir_tx_framer_if #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) msg ();

    ir_tx_framer #(
        .MAX_LEN        (MAX_LEN),
        .SBD            (SBD),
        .BSD            (BSD),
        .BBD0           (BBD0),
        .BBD1           (BBD1),
        .RGD            (RGD),
        .CARRIER_PERIOD (CP),
        .CARRIER_HIGH   (CH),
        .REP_W          (REP_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .msg          (msg),
        .abort_in     (abort_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .envelope_out (envelope_out),
        .signal_out   (signal_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_env[$];
    bit exp_sig[$];
    int ph;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic seg(input bit m, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_env.push_back(m);
            exp_sig.push_back(m && ((ph % CP) < CH));
            ph++;
        end
    endtask

    // Expected per-cycle mark level and modulated level, starting at the first SYNC cycle.
    task automatic build_model(input logic [7:0] d, input int len, input bit lsb, input int rep);
        int n;
        bit bits[$];
        bit par;
        n = (len == 0) ? MAX_LEN : len;
        par = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits.push_back(lsb ? d[i] : d[n - 1 - i]);
            par = par ^ d[i];
        end
`ifdef IR_TX_PARITY_EN
        bits.push_back(par);
`endif
        exp_env.delete();
        exp_sig.delete();
        for (int f = 0; f <= rep; f++) begin
            ph = 0;
            seg(1'b1, SBD);
            foreach (bits[i]) begin
                seg(1'b0, BSD);
                seg(1'b1, bits[i] ? BBD1 : BBD0);
            end
            seg(1'b0, BSD);
            if (f < rep) seg(1'b0, RGD);
        end
    endtask

    task automatic drive_msg(input logic [7:0] d, input int len, input bit lsb, input int rep);
        msg.data_in       = d;
        msg.len_in        = 4'(len);
        msg.lsb_first_in  = lsb;
        msg.repeat_in     = 4'(rep);
        msg.data_valid_in = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; runs the whole transmission cycle by cycle.
    task automatic run_frame(input logic [7:0] d, input int len, input bit lsb, input int rep,
                             input bit hold, input bit abort_at_accept, input string tag);
        int t;
        build_model(d, len, lsb, rep);
        t = exp_env.size();
        drive_msg(d, len, lsb, rep);
        abort_in = abort_at_accept;
        for (int k = 0; k <= t + 1; k++) begin
            @(negedge clk_in);
            if (k == 0) begin
                abort_in = 1'b0;
                if (!hold) msg.data_valid_in = 1'b0;
            end
            if (hold && k > 0 && k < t - 1) begin
                msg.data_in      = 8'($urandom);
                msg.len_in       = 4'($urandom_range(0, 8));
                msg.lsb_first_in = 1'($urandom);
            end
            if (k == t - 1) msg.data_valid_in = 1'b0;
            check({tag, " env"}, 32'(envelope_out),
                  32'((k >= 1 && k <= t) ? exp_env[k - 1] : 1'b0));
            check({tag, " sig"}, 32'(signal_out),
                  32'((k >= 1 && k <= t) ? exp_sig[k - 1] : 1'b0));
            check({tag, " busy"}, 32'(busy_out), 32'(k < t));
            check({tag, " ready"}, 32'(msg.ready_out), 32'(k >= t));
            check({tag, " done"}, 32'(done_out), 32'(k == t));
        end
    endtask

    // Abort (or reset) asserted after edge 'at' of a transmission.
    task automatic run_cut(input logic [7:0] d, input int len, input bit lsb, input int rep,
                           input int at, input bit use_rst, input string tag);
        build_model(d, len, lsb, rep);
        drive_msg(d, len, lsb, rep);
        for (int k = 0; k <= at; k++) begin
            @(negedge clk_in);
            if (k == 0) msg.data_valid_in = 1'b0;
            if (k >= 1) check({tag, " env pre"}, 32'(envelope_out), 32'(exp_env[k - 1]));
        end
        abort_in = 1'b1;
        rst_in   = use_rst;
        @(negedge clk_in);
        abort_in = 1'b0;
        rst_in   = 1'b0;
        check({tag, " env cut"}, 32'(envelope_out), 32'(0));
        check({tag, " sig cut"}, 32'(signal_out), 32'(0));
        check({tag, " ready cut"}, 32'(msg.ready_out), 32'(1));
        check({tag, " busy cut"}, 32'(busy_out), 32'(0));
        check({tag, " done cut"}, 32'(done_out), 32'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            check({tag, " done after"}, 32'(done_out), 32'(0));
            check({tag, " env after"}, 32'(envelope_out), 32'(0));
            check({tag, " ready after"}, 32'(msg.ready_out), 32'(1));
        end
    endtask

    initial begin
        rst_in            = 1'b1;
        abort_in          = 1'b0;
        msg.data_valid_in = 1'b0;
        msg.data_in       = '0;
        msg.len_in        = '0;
        msg.lsb_first_in  = 1'b0;
        msg.repeat_in     = '0;
        repeat (3) @(negedge clk_in);
        check("reset ready", 32'(msg.ready_out), 32'(1));
        check("reset busy", 32'(busy_out), 32'(0));
        check("reset done", 32'(done_out), 32'(0));
        check("reset env", 32'(envelope_out), 32'(0));
        check("reset sig", 32'(signal_out), 32'(0));
        rst_in = 1'b0;
        @(negedge clk_in);

        // Abort while idle must not disturb anything.
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("idle abort ready", 32'(msg.ready_out), 32'(1));

        run_frame(8'b1011, 4, 1'b0, 0, 1'b0, 1'b0, "s1 msb");
        run_frame(8'b1011, 4, 1'b1, 0, 1'b0, 1'b0, "s2 lsb");
        run_frame(8'b1011, 4, 1'b0, 2, 1'b0, 1'b0, "s3 rep2");
        run_frame(8'hFF, 0, 1'b0, 0, 1'b0, 1'b0, "s4 len0");
        run_cut(8'b1011, 4, 1'b0, 0, 12, 1'b0, "s5 abort");
        run_frame(8'b0110, 4, 1'b0, 0, 1'b0, 1'b0, "s5 after");
        run_frame(8'b1011, 4, 1'b0, 1, 1'b1, 1'b0, "s6 hold");
        run_frame(8'h5A, 8, 1'b1, 0, 1'b0, 1'b1, "valid+abort idle");
        run_cut(8'hC3, 8, 1'b0, 1, 30, 1'b1, "reset mid");

        for (int r = 0; r < 8; r++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 8)), 1'($urandom),
                      int'($urandom_range(0, 2)), 1'($urandom), 1'b0, "rand");
        end
        run_cut(8'($urandom), int'($urandom_range(1, 8)), 1'($urandom), 1,
                int'($urandom_range(1, 40)), 1'b0, "rand abort");
        run_frame(8'($urandom), int'($urandom_range(0, 8)), 1'($urandom), 0,
                  1'b0, 1'b0, "rand post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_tx_framer.md
Name: ir_tx_framer

Overview:
Parametrised successor to the single-message IR transmitter. Accepts a variable-length message through a valid/ready handshake and serialises it as pulse-width-coded marks on a carrier. Supports a selectable bit order, a repeat count with inter-frame gap, and abort. Sits between the message builder and the IR LED pin driver; one clock domain.

Parameters:
MAX_LEN, 32, maximum payload bits per message
SBD, 240_000, sync mark duration (cycles)
BSD, 60_000, space before each bit and tail space (cycles)
BBD0, 60_000, mark duration for bit 0 (cycles)
BBD1, 120_000, mark duration for bit 1 (cycles)
RGD, 1_000_000, space between repeated frames (cycles)
CARRIER_PERIOD, 2_560, carrier period (cycles, >=2)
CARRIER_HIGH, 1_280, carrier high cycles per period (1..CARRIER_PERIOD-1)
REP_W, 4, width of repeat count

Ports:
clk_in  in  1  system clock (100 MHz)
rst_in  in  1  synchronous reset, active-high
data_valid_in  in  1  message offered
ready_out  out  1  block can accept a message (IDLE)
data_in  in  MAX_LEN  payload, bits [len-1:0] used
len_in  in  $clog2(MAX_LEN+1)  payload length; 0 means MAX_LEN
lsb_first_in  in  1  0 = MSB first, 1 = LSB first
repeat_in  in  REP_W  extra repeats (total frames = repeat_in+1)
abort_in  in  1  cancel transmission
busy_out  out  1  transmission in progress
done_out  out  1  1-cycle pulse when the final frame completes
envelope_out  out  1  unmodulated mark envelope, registered
signal_out  out  1  carrier-modulated LED drive, registered

Behaviour:
- Reset: state IDLE; ready_out=1; busy_out=0; done_out=0; envelope_out=0; signal_out=0; all counters 0.
- Handshake: accept on the edge where data_valid_in && ready_out. Latch data, length (len 0 becomes MAX_LEN), bit order and repeat count. Inputs are ignored when not in IDLE.
- States: IDLE, SYNC, SPACE, MARK, TAIL, GAP. Each timed state lasts exactly its parameter in cycles (counter 0..N-1). No off-by-one extra cycle.
- IDLE -> SYNC on accept.
- SYNC(SBD) -> SPACE.
- SPACE(BSD) -> MARK. On entry the next bit is selected.
- MARK(BBD0 or BBD1 by bit) -> SPACE if bits remain, else TAIL.
- TAIL(BSD) -> GAP if repeats remain, else IDLE with done_out pulse.
- GAP(RGD) -> SYNC, repeat counter decremented, same bits resent.
- Bit order: MSB-first sends data[len-1] down to data[0]. LSB-first sends data[0] up to data[len-1]. Implement with a latched shift register plus a bit counter; each repeat restores from the latched copy.
- Mark states are SYNC and MARK. envelope_out is registered from the current state (1-cycle lag).
- signal_out = registered (mark & carrier).
- Carrier counter restarts at 0 on entry to SYNC, so the phase is identical every frame. The carrier is high for counts 0..CARRIER_HIGH-1.
- busy_out=1 and ready_out=0 in every state except IDLE. busy_out drops on the same edge done_out rises.
- Frame length (cycles) = SBD + sum over bits (BSD + BBDx) + BSD.
- abort_in (any non-IDLE state): next edge goes to IDLE, envelope_out and signal_out go to 0, no done_out. abort_in in IDLE has no effect; a simultaneous valid in IDLE is still accepted.
- rst_in overrides everything mid-frame, including abort.

Optional Feature:
IR_TX_PARITY_EN:
- Defined: one even-parity bit (XOR of the len payload bits) is appended after the last payload bit of every frame, with the same SPACE+MARK encoding. The frame gains BSD+BBDx cycles.
- Undefined: no parity bit; frames contain exactly len bits.

Decomposition:
- Package ir_pkg: state enum ir_tx_state_t, bit-length localparam helpers, parity function.
- Sub-module ir_carrier_gen: CARRIER_PERIOD/CARRIER_HIGH counter with sync restart input and carrier output. It replaces the fixed-duty pwm use.

Test Plan:
Bench parameters for all scenarios: SBD=8, BSD=2, BBD0=2, BBD1=4, RGD=6, CARRIER_PERIOD=2, CARRIER_HIGH=1, MAX_LEN=8.
1. data=4'b1011, len=4, MSB-first, repeat=0 -> envelope marks 8,4,2,4,4 cycles; frame 32 cycles; done_out one pulse; busy high 32 cycles.
2. Same data, LSB-first -> mark order 8,4,4,2,4.
3. repeat=2 -> three identical frames separated by 6-cycle gaps; single done_out after the third; carrier phase identical at each SYNC start.
4. len=0, data=8'hFF -> 8 bits of BBD1; frame 8+8*6+2=58 cycles.
5. abort_in in cycle 12 of scenario 1 -> signal_out/envelope_out 0 next cycle, ready_out 1, no done_out. A new valid is then accepted normally.
6. data_valid_in held high while busy with changed data -> ignored. With IR_TX_PARITY_EN, 4'b1011 adds a bit-1 mark of 4 cycles (38-cycle frame).
